wait_state_memory_controller: RTL



---
 rtl/wait_state_memory_controller_if.sv | 24 ++
 rtl/wait_state_memory_controller.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/wait_state_memory_controller_if.sv
// Processor memory bus between the core (master) and the wait-state memory controller (slave).
interface wait_state_memory_controller_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              abort;
    logic              n_wait;
    logic              write;
    logic [1:0]        size;
    logic [1:0]        prot;
    logic [1:0]        trans;

    modport master (
        output addr, wdata, write, size, prot, trans,
        input  rdata, abort, n_wait
    );

    modport slave (
        input  addr, wdata, write, size, prot, trans,
        output rdata, abort, n_wait
    );
endinterface

// File: rtl/wait_state_memory_controller.sv
// Byte-addressed big-endian on-chip memory with programmable wait states and access aborts.
//   state  | meaning
//   S_IDLE | no access in flight, request may be sampled
//   S_WAIT | counting down wait cycles for the latched request
//   S_RESP | response cycle: rdata/abort show the completed access
module wait_state_memory_controller #(
    parameter int ADDR_W          = 32,
    parameter int DEPTH_BYTES     = 8192,
    parameter int WAIT_STATES     = 0,
    parameter int SEQ_WAIT_STATES = 0,
    parameter int PROT_BASE       = 0
) (
    input  logic clk,
    input  logic n_reset,
    wait_state_memory_controller_if.slave bus
);
    localparam int IDX_W    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int MAX_WAIT = (WAIT_STATES > SEQ_WAIT_STATES) ? WAIT_STATES : SEQ_WAIT_STATES;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              lat_write;
    logic [1:0]        lat_size;
    logic              lat_priv;
    logic [31:0]       rdata_q;
    logic              abort_q;

    int                live_n;
    logic              sample, exec, in_wait;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_wdata;
    logic              cur_write, cur_priv;
    logic [1:0]        cur_size, last_off;
    logic [ADDR_W:0]   last_byte;
    logic              size_err, align_err, range_err, prot_err, err;
    logic [IDX_W-1:0]  idx0, idx1, idx2, idx3;
    logic [31:0]       rd_word;
    logic [7:0]        mem [DEPTH_BYTES];
    logic [1:0]        unused_bits;

    assign unused_bits = {bus.prot[0], cur_priv};

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_write <= 1'b0;
            lat_size  <= 2'b00;
            lat_priv  <= 1'b0;
            rdata_q   <= '0;
            abort_q   <= 1'b0;
        end else begin
            state   <= state_d;
            abort_q <= exec && err;
            if (sample) begin
                lat_addr  <= bus.addr;
                lat_wdata <= bus.wdata;
                lat_write <= bus.write;
                lat_size  <= bus.size;
                lat_priv  <= bus.prot[1];
                if (live_n != 0) cnt <= CNT_W'(live_n - 1);
            end else if (in_wait && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (exec && err)
                rdata_q <= '0;
            else if (exec && !cur_write)
                rdata_q <= rd_word;
        end
    end

    always_comb begin
        in_wait = (state == S_WAIT);
        live_n  = bus.trans[0] ? SEQ_WAIT_STATES : WAIT_STATES;
        sample  = !in_wait && bus.trans[1];
        exec    = (sample && live_n == 0) || (in_wait && cnt == '0);
        state_d = state;
        case (state)
            S_IDLE, S_RESP: state_d = sample ? ((live_n == 0) ? S_RESP : S_WAIT) : S_IDLE;
            S_WAIT:         if (cnt == '0) state_d = S_RESP;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.n_wait = (state != S_WAIT);
        bus.abort  = abort_q;
        bus.rdata  = rdata_q;
    end

    // Zero-wait accesses execute on the sampling edge, so they use the live bus fields.
    always_comb begin
        cur_addr  = in_wait ? lat_addr  : bus.addr;
        cur_wdata = in_wait ? lat_wdata : bus.wdata;
        cur_write = in_wait ? lat_write : bus.write;
        cur_size  = in_wait ? lat_size  : bus.size;
        cur_priv  = in_wait ? lat_priv  : bus.prot[1];
        case (cur_size)
            2'b00:   last_off = 2'd0;
            2'b01:   last_off = 2'd1;
            default: last_off = 2'd3;
        endcase
        last_byte = {1'b0, cur_addr} + {{(ADDR_W-1){1'b0}}, last_off};
        size_err  = (cur_size == 2'b11);
        align_err = (cur_size == 2'b01 && cur_addr[0]) ||
                    (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
        range_err = (last_byte >= (ADDR_W+1)'(DEPTH_BYTES));
        err       = size_err || align_err || range_err || prot_err;
        idx0      = cur_addr[IDX_W-1:0];
        idx1      = idx0 + IDX_W'(1);
        idx2      = idx0 + IDX_W'(2);
        idx3      = idx0 + IDX_W'(3);
        case (cur_size)
            2'b00:   rd_word = {24'b0, mem[idx0]};
            2'b01:   rd_word = {16'b0, mem[idx0], mem[idx1]};
            default: rd_word = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
        endcase
    end

    if (PROT_BASE != 0) begin : g_prot
        assign prot_err = (cur_addr < ADDR_W'(PROT_BASE)) && !cur_priv;
    end else begin : g_no_prot
        assign prot_err = 1'b0;
    end

    // Memory has no reset; the n_reset term keeps a request seen during reset from landing.
    always_ff @(posedge clk) begin
        if (exec && !err && cur_write && n_reset) begin
            case (cur_size)
                2'b00: mem[idx0] <= cur_wdata[7:0];
                2'b01: begin
                    mem[idx0] <= cur_wdata[15:8];
                    mem[idx1] <= cur_wdata[7:0];
                end
                default: begin
                    mem[idx0] <= cur_wdata[31:24];
                    mem[idx1] <= cur_wdata[23:16];
                    mem[idx2] <= cur_wdata[15:8];
                    mem[idx3] <= cur_wdata[7:0];
                end
            endcase
        end
    end
endmodule
